// File: rtl/conv_pkg.sv
// Shared constants and types for the conv2d datapath (window feeder and convolution stage).
package conv_pkg;

  localparam int IMG_W_DEF = 5;
  localparam int IMG_H_DEF = 5;
  localparam int DW_DEF    = 12;
  localparam int AW_DEF    = 17;
  localparam int WIN_N     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_shift_chain.sv
// Enable-gated pixel delay line; tap 0 holds the most recently shifted-in pixel.
module pixel_shift_chain #(
  parameter int DEPTH = 13,
  parameter int DW    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic [DW-1:0]             i_din,
  output logic [DEPTH-1:0][DW-1:0]  o_taps
);

  logic [DEPTH-1:0][DW-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= '0;
    end else if (i_en) begin
      r_chain <= {r_chain[DEPTH-2:0], i_din};
    end
  end

  assign o_taps = r_chain;

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-scans a source image and presents each fully-valid 3x3 neighbourhood,
// with its destination index, over a valid/ready handshake.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DW-1:0]         d_in,
  output logic [AW-1:0]         ReadAddress,
  output logic [WIN_N*DW-1:0]   win_out,
  output logic [AW-1:0]         out_addr,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  ready
);

  localparam int DEPTH = 2*IMG_W + 3;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W*IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [AW-1:0] OUT_W     = AW'(IMG_W - 2);

  state_t                   r_state;
  logic [AW-1:0]            r_addr;
  logic [AW-1:0]            r_out_addr;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic                     r_win_valid;
  logic                     r_ready;

  logic                     w_capture;
  logic                     w_qualify;
  logic                     w_last;
  logic [AW-1:0]            w_dest;
  logic [DEPTH-1:0][DW-1:0] w_taps;

  // A pixel is taken whenever the output slot is free or being emptied this cycle.
  assign w_capture = (r_state == RUN) && (!r_win_valid || win_ready);
  assign w_qualify = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_last    = (r_addr == LAST_ADDR);
  assign w_dest    = (AW'(r_row) - AW'(2)) * OUT_W + (AW'(r_col) - AW'(2));

  pixel_shift_chain #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_chain (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_capture),
    .i_din  (d_in),
    .o_taps (w_taps)
  );

  // Window element k = 3*row + col maps back to the pixel (2-row) lines and (2-col) pixels ago.
  for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_win_col
      assign win_out[(gi*3 + gj)*DW +: DW] = w_taps[(2-gi)*IMG_W + (2-gj)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_out_addr  <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_addr  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          if (w_capture) begin
            r_win_valid <= w_qualify;
            if (w_qualify) begin
              r_out_addr <= w_dest;
            end
            if (w_last) begin
              r_state <= DRAIN;
            end else begin
              r_addr <= r_addr + AW'(1);
              if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!r_win_valid || win_ready) begin
            r_win_valid <= 1'b0;
            r_state     <= IDLE;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ReadAddress = r_addr;
  assign out_addr    = r_out_addr;
  assign win_valid   = r_win_valid;
  assign ready       = r_ready;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on a 5x5 ramp image p(r,c) = r*5 + c + 1.
module tb_conv_window_buffer;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           win_ready = 1'b0;
  logic [11:0]    d_in;
  logic [16:0]    ReadAddress;
  logic [107:0]   win_out;
  logic [16:0]    out_addr;
  logic           win_valid;
  logic           ready;

  int ncmp = 0;
  int nerr = 0;
  int nwin;
  int total;

  always #5 clk = ~clk;

  // Zero-latency source memory: the ramp value is simply address + 1.
  assign d_in = 12'(ReadAddress + 17'd1);

  conv_window_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .d_in        (d_in),
    .ReadAddress (ReadAddress),
    .win_out     (win_out),
    .out_addr    (out_addr),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .ready       (ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Window n is centred on pixel (n/3+1, n%3+1); element k sits at row offset k/3, col offset k%3.
  function automatic logic [107:0] exp_win(input int n);
    int r;
    int c;
    logic [107:0] w;
    r = n / 3;
    c = n % 3;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[k*12 +: 12] = 12'((r + k/3) * 5 + (c + k%3) + 1);
    end
    return w;
  endfunction

  // mode 0: always ready, 1: 5-cycle stall on out_addr 3, 2: start pulse at address 7, 3: random ready
  task automatic run_frame(input int mode, input string tag, output int n_out);
    int           exp_n;
    int           cyc;
    int           stall_left;
    bit           stalled;
    bit           pulsed;
    bit           held;
    bit           first_seen;
    logic         rdy;
    logic [107:0] h_win;
    logic [16:0]  h_addr;
    logic [16:0]  h_ra;
    exp_n = 0; cyc = 0; stall_left = 0;
    stalled = 0; pulsed = 0; held = 0; first_seen = 0;
    h_win = '0; h_addr = '0; h_ra = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " ready after start"}, ready, 1'b0);
    while (!ready && cyc < 400) begin
      if (held) begin
        chk({tag, " hold win_out"}, win_out, h_win);
        chk({tag, " hold out_addr"}, out_addr, h_addr);
        chk({tag, " hold ReadAddress"}, ReadAddress, h_ra);
        chk({tag, " hold win_valid"}, win_valid, 1'b1);
      end
      if (win_valid && !first_seen) begin
        first_seen = 1;
        chk({tag, " ReadAddress at first window"}, ReadAddress, 17'd13);
      end
      rdy = 1'b1;
      if (mode == 1 && win_valid && out_addr == 17'd3 && !stalled) begin
        stalled = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      if (mode == 3) rdy = 1'($urandom_range(0, 1));
      if (mode == 2 && ReadAddress == 17'd7 && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      win_ready = rdy;
      if (win_valid && rdy) begin
        chk({tag, " out_addr"}, out_addr, 17'(exp_n));
        chk({tag, " win_out"}, win_out, exp_win(exp_n));
        $display("%s window %0d: out_addr=%0d win_out=%0h", tag, exp_n, out_addr, win_out);
        exp_n++;
      end
      held = win_valid && !rdy;
      h_win = win_out;
      h_addr = out_addr;
      h_ra = ReadAddress;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, " frame completes"}, ready, 1'b1);
    chk({tag, " window count"}, 32'(exp_n), 32'd9);
    chk({tag, " win_valid idle"}, win_valid, 1'b0);
    chk({tag, " final ReadAddress"}, ReadAddress, 17'd24);
    n_out = exp_n;
  endtask

  initial begin
    #1 rst = 1'b0;
    #10;
    chk("reset win_valid", win_valid, 1'b0);
    chk("reset ReadAddress", ReadAddress, 17'd0);
    chk("reset ready", ready, 1'b1);
    chk("reset win_out", win_out, 108'd0);
    chk("reset out_addr", out_addr, 17'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_frame(0, "ramp", nwin);
    run_frame(1, "stall", nwin);
    run_frame(2, "busy", nwin);

    // Abandon a frame part-way and confirm the next one is clean.
    win_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && ReadAddress != 17'd10; i++) begin
      @(posedge clk); #1;
    end
    chk("midreset reached address 10", ReadAddress, 17'd10);
    #2 rst = 1'b0;
    #1;
    chk("midreset win_valid", win_valid, 1'b0);
    chk("midreset ReadAddress", ReadAddress, 17'd0);
    chk("midreset ready", ready, 1'b1);
    chk("midreset win_out", win_out, 108'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_frame(0, "postreset", nwin);

    total = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(3, "random", nwin);
      total += nwin;
    end
    chk("random total windows", 32'(total), 32'd27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
